// File: rtl/nios_sopc_led_sequencer.sv
// LED pattern sequencer: CPU-programmed pattern/period/length, autonomous
// one-write-per-step Avalon-MM master towards the LED PIO s1 slave.
// Optional interrupt on one-shot completion: define NIOS_SOPC_LED_SEQ_IRQ_EN.
module nios_sopc_led_sequencer #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned LEN_W    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [1:0]  led_address,
  output logic        led_chipselect,
  output logic        led_write_n,
  output logic [31:0] led_writedata,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_HOLD,
    S_FINISH,
    S_ABORT
  } state_t;

  state_t              state;
  logic                en;
  logic                oneshot;
  logic                done;
  logic                irq_en;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic [31:0]         pattern;
  logic [LEN_W-1:0]    length;
  logic [LEN_W-1:0]    idx;

  logic                cfg_wr;
  logic                ctrl_wr;
  logic                busy;
  logic                wrap;
  logic [LEN_W-1:0]    idx_next;
  logic [PERIOD_W-1:0] hold_init;
  logic                unused_ok;

  assign cfg_wr    = cfg_chipselect & ~cfg_write_n;
  assign ctrl_wr   = cfg_wr & (cfg_address == 2'd0);
  assign busy      = (state != S_IDLE);
  // >= so that lowering LENGTH below the live index still wraps or finishes
  assign wrap      = (idx >= length);
  assign idx_next  = wrap ? '0 : idx + LEN_W'(1);
  // PERIOD of 0 or 1 behaves as 2: one STEP cycle plus one HOLD cycle
  assign hold_init = (period < PERIOD_W'(2)) ? '0 : period - PERIOD_W'(2);
  assign led_address = 2'b00;
  assign unused_ok = &{1'b0, cfg_writedata};

  // Software-visible registers; hardware completion overrides software writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      done    <= 1'b0;
      period  <= '0;
      pattern <= '0;
      length  <= '0;
    end else begin
      if (ctrl_wr) begin
        en      <= cfg_writedata[0];
        oneshot <= cfg_writedata[1];
        if (cfg_writedata[2]) done <= 1'b0;
      end
      if (cfg_wr && cfg_address == 2'd1) period  <= cfg_writedata[PERIOD_W-1:0];
      if (cfg_wr && cfg_address == 2'd2) pattern <= cfg_writedata;
      if (cfg_wr && cfg_address == 2'd3) length  <= cfg_writedata[LEN_W-1:0];
      if (state == S_FINISH) begin
        done <= 1'b1;
        en   <= 1'b0;
      end
    end
  end

`ifdef NIOS_SOPC_LED_SEQ_IRQ_EN
  // Interrupt enable bit, CTRL bit3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en <= cfg_writedata[3];
    end
  end

  assign irq = done & irq_en;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Sequencer FSM; LED bus strobes are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      counter        <= '0;
      led_chipselect <= 1'b0;
      led_write_n    <= 1'b1;
      led_writedata  <= '0;
    end else begin
      led_chipselect <= 1'b0;
      led_write_n    <= 1'b1;
      case (state)
        S_IDLE: begin
          if (en) begin
            state          <= S_STEP;
            idx            <= '0;
            led_chipselect <= 1'b1;
            led_write_n    <= 1'b0;
            led_writedata  <= {31'b0, pattern[0]};
          end
        end
        S_STEP: begin
          if (!en) begin
            state          <= S_ABORT;
            led_chipselect <= 1'b1;
            led_write_n    <= 1'b0;
            led_writedata  <= '0;
          end else begin
            counter <= hold_init;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!en) begin
            state          <= S_ABORT;
            led_chipselect <= 1'b1;
            led_write_n    <= 1'b0;
            led_writedata  <= '0;
          end else if (counter == '0) begin
            led_chipselect <= 1'b1;
            led_write_n    <= 1'b0;
            if (wrap && oneshot) begin
              state         <= S_FINISH;
              led_writedata <= '0;
            end else begin
              state         <= S_STEP;
              idx           <= idx_next;
              led_writedata <= {31'b0, pattern[idx_next]};
            end
          end else begin
            counter <= counter - PERIOD_W'(1);
          end
        end
        S_FINISH: state <= S_IDLE;
        S_ABORT:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Zero-wait-state register readback
  always_comb begin
    cfg_readdata = '0;
    case (cfg_address)
      2'd0: cfg_readdata = {15'b0, busy, 12'b0, irq_en, done, oneshot, en};
      2'd1: cfg_readdata = 32'(period);
      2'd2: cfg_readdata = pattern;
      2'd3: cfg_readdata = (32'(idx) << 8) | 32'(length);
      default: cfg_readdata = '0;
    endcase
  end

endmodule

// File: doc/nios_sopc_led_sequencer.md
# nios_sopc_led_sequencer

LED blink/pattern sequencer that sits between the Nios II data master and the LED PIO in the Nios_sopc system. The CPU configures a pattern, step length and step period through an Avalon-MM slave port. The block then autonomously drives the LED PIO s1 slave through a write-only Avalon-MM master port, one write per pattern step, so the CPU no longer bit-bangs the LED.

## Interface
Parameters:
- PERIOD_W, 24, width of the PERIOD register (step period in clk cycles)
- LEN_W, 5, width of the LENGTH register (up to 2^LEN_W steps, max 32)

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  reset, asynchronous assert, active-low
- cfg_address  in  2  config register select
- cfg_chipselect  in  1  config slave select
- cfg_write_n  in  1  config write strobe, active-low
- cfg_writedata  in  32  config write data
- cfg_readdata  out  32  config read data; combinational from cfg_address, zero wait states
- led_address  out  2  to PIO s1; constant 0
- led_chipselect  out  1  to PIO s1
- led_write_n  out  1  to PIO s1, active-low
- led_writedata  out  32  to PIO s1; {31'b0, led_bit}
- irq  out  1  level interrupt on one-shot completion (see Configuration)

## Operation
- Register map (word address):
  - 0 CTRL: bit0 EN (r/w); bit1 ONESHOT (r/w); bit2 DONE (read; write 1 clears); bit16 BUSY (read-only).
  - 1 PERIOD[PERIOD_W-1:0]: clk cycles per step; values 0 and 1 are treated as 2.
  - 2 PATTERN[31:0]: bit i is the LED value of step i.
  - 3 LENGTH[LEN_W-1:0]: number of steps minus 1. Read returns step index in bits [LEN_W+7:8].
- A config write occurs when cfg_chipselect=1 and cfg_write_n=0; the write takes effect on the next clk edge.
- FSM states:
  - IDLE: BUSY=0. Leaves on EN=1 → STEP with idx=0.
  - STEP (1 cycle): led_chipselect=1, led_write_n=0, led_bit=PATTERN[idx]; counter ← PERIOD_eff−2; → HOLD.
  - HOLD: counter decrements each cycle. At counter==0:
    - idx≥LENGTH and ONESHOT=1 → FINISH.
    - idx≥LENGTH and ONESHOT=0 → idx←0, STEP.
    - otherwise idx←idx+1, STEP.
  - FINISH (1 cycle): write led_bit=0; set DONE; clear EN; → IDLE.
  - ABORT (1 cycle): entered from STEP/HOLD when EN reads 0 (software cleared it). Writes led_bit=0; DONE unchanged; → IDLE.
- Register updates while running:
  - PERIOD is sampled only in STEP.
  - PATTERN and LENGTH are used live. The ≥ compare guarantees wrap or finish if LENGTH is lowered below idx.
  - Writing EN=1 while running does not restart the sequence.
  - A CTRL write with EN=0 and the FSM in HOLD with counter==0 takes the abort path.
- Outside STEP/FINISH/ABORT: led_chipselect=0, led_write_n=1. led_writedata holds its last value.

## Timing
- Reset values:
  - All registers 0; state IDLE; idx 0; counter 0.
  - led_chipselect=0, led_write_n=1, led_writedata=0, led_address=0, irq=0.
  - cfg_readdata reflects the reset registers.
- Start latency: CTRL write with EN=1 at edge N → STEP during cycle N+1. The PIO output updates at edge N+2.
- Step spacing: consecutive LED writes occur exactly PERIOD_eff cycles apart, including across a wrap.
- FINISH/ABORT: the off-write occurs PERIOD_eff cycles after the last STEP for FINISH, and 1 cycle after EN is cleared for ABORT.
- Simultaneous events: a software DONE-clear and a hardware DONE-set in the same cycle resolve to set.
- Reset mid-operation: immediate return to the reset state. No off-write is issued; the PIO is reset by the same reset_n.

## Configuration
- Macro NIOS_SOPC_LED_SEQ_IRQ_EN.
- Defined: irq = DONE & CTRL bit3 IRQ_EN (r/w); irq clears when DONE is cleared.
- Undefined: CTRL bit3 reads 0 and ignores writes; irq is tied 0. DONE still operates for polling.

## Test plan
- Reset: assert reset_n=0 mid-HOLD → all outputs at reset values; cfg_readdata=0 for all addresses after release.
- Loop: PATTERN=0b1011, LENGTH=3, PERIOD=5, CTRL=0x1 → LED writes of 1,1,0,1,1,1,0,1… exactly 5 cycles apart; BUSY=1.
- One-shot: PATTERN=0b01, LENGTH=1, PERIOD=4, CTRL=0x3 → writes 1,0, then off-write 0 four cycles later; DONE=1, EN=0, BUSY=0.
- Minimum period: PERIOD=0 then PERIOD=1, LENGTH=0, PATTERN=1 → writes every 2 cycles in both cases.
- Abort: clear EN during HOLD → single write of 0 on the next cycle, then IDLE; DONE stays 0.
- IRQ (macro defined): one-shot with IRQ_EN=1 → irq rises with DONE; writing CTRL=0x4 drops irq the next cycle. Macro undefined → irq stays 0.
